pair_sum_stage: RTL and testbench

Downstream consumer of the ping-pong element FIFO: drains 96-bit entries through the FIFO's out port (first/deq) and emits the sum of the two halves of each entry into a downstream PipeIn. It is a two-register pipeline (fetch register A, result register B) with full backpressure, a synchronous flush, and a running output counter for the ivector datapath status logic.

---
 rtl/pair_sum_stage_if.sv | 24 ++
 rtl/pair_sum_stage.sv | 71 +++++++
 tb/tb_pair_sum_stage.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pair_sum_stage_if.sv
// Port bundles for pair_sum_stage: the element FIFO's out port (first/deq)
// and the downstream PipeIn enqueue port.
interface pair_sum_stage_if #(
  parameter int width = 96
);
  logic [width-1:0] first;
  logic             first__RDY;
  logic             deq__RDY;
  logic             deq__ENA;

  modport master (output first, first__RDY, deq__RDY, input deq__ENA);
  modport slave  (input first, first__RDY, deq__RDY, output deq__ENA);
endinterface

interface pipe_in_if #(
  parameter int outw = 49
);
  logic [outw-1:0] enq_v;
  logic            enq__ENA;
  logic            enq__RDY;

  modport master (output enq_v, enq__ENA, input enq__RDY);
  modport slave  (input enq_v, enq__ENA, output enq__RDY);
endinterface

// File: rtl/pair_sum_stage.sv
// Drains 96-bit FIFO entries and emits hi+lo (with full carry) downstream.
// Fetch register A feeds result register B; full backpressure, flush, result counter.
module pair_sum_stage #(
  parameter int width = 96
) (
  input  logic             CLK,
  input  logic             nRST,
  pair_sum_stage_if.slave  in,
  pipe_in_if.master        out,
  input  logic             clear,
  output logic [31:0]      count
);
  localparam int half = width / 2;
  localparam int outw = half + 1;

  logic             r_a_valid;
  logic [width-1:0] r_a_data;
  logic             r_b_valid;
  logic [outw-1:0]  r_b_data;
  logic [31:0]      r_count;

  logic             w_b_fire;
  logic             w_a_adv;
  logic             w_deq;
  logic [outw-1:0]  w_sum;

  // enq__RDY reaches deq__ENA combinationally so a stalled pipe restarts without a bubble.
  always_comb begin
    w_b_fire = r_b_valid && out.enq__RDY;
    w_a_adv  = r_a_valid && (!r_b_valid || w_b_fire);
    w_deq    = in.first__RDY && in.deq__RDY && (!r_a_valid || w_a_adv) && !clear;
    w_sum    = {1'b0, r_a_data[width-1:half]} + {1'b0, r_a_data[half-1:0]};
  end

  assign in.deq__ENA  = w_deq;
  assign out.enq__ENA = r_b_valid;
  assign out.enq_v    = r_b_data;
  assign count        = r_count;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_a_valid <= 1'b0;
      r_a_data  <= '0;
      r_b_valid <= 1'b0;
      r_b_data  <= '0;
      r_count   <= '0;
    end else begin
      if (w_deq) begin
        r_a_data  <= in.first;
        r_a_valid <= 1'b1;
      end else if (w_a_adv) begin
        r_a_valid <= 1'b0;
      end

      // A flushed entry never lands in B, so b_data keeps its stale value.
      if (w_a_adv) begin
        if (!clear) r_b_data <= w_sum;
        r_b_valid <= 1'b1;
      end else if (w_b_fire) begin
        r_b_valid <= 1'b0;
      end

      if (clear) begin
        r_a_valid <= 1'b0;
        r_b_valid <= 1'b0;
      end

      if (w_b_fire) r_count <= r_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_pair_sum_stage.sv
// Directed bench for pair_sum_stage: the bench plays the element FIFO and the
// downstream sink; expected sums are queued at dequeue and popped at enqueue.
module tb_pair_sum_stage;
  localparam int W  = 96;
  localparam int H  = 48;
  localparam int OW = 49;

  logic        CLK   = 1'b0;
  logic        nRST  = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] count;

  pair_sum_stage_if #(.width(W)) in_if ();
  pipe_in_if #(.outw(OW))        out_if ();

  pair_sum_stage #(.width(W)) dut (
    .CLK   (CLK),
    .nRST  (nRST),
    .in    (in_if),
    .out   (out_if),
    .clear (clear),
    .count (count)
  );

  always #5 CLK = ~CLK;

  logic [W-1:0]  src[$];
  logic [OW-1:0] sb[$];
  logic [OW-1:0] got[$];
  logic          src_en  = 1'b0;
  logic          deq_rdy = 1'b1;
  int cyc = 0, pass_cnt = 0, total_cnt = 0, fail_cnt = 0;
  int deq_cnt = 0, fire_cnt = 0;
  int first_deq = -1, last_deq = -1, first_fire = -1, last_fire = -1;
  logic [OW-1:0] last_val = '0;
  logic [31:0]   exp_count = '0;

  function automatic logic [OW-1:0] ref_sum(input logic [W-1:0] e);
    return {1'b0, e[W-1:H]} + {1'b0, e[H-1:0]};
  endfunction

  function automatic logic [W-1:0] mk(input logic [H-1:0] hi, input logic [H-1:0] lo);
    return {hi, lo};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    in_if.first__RDY = src_en && (src.size() != 0);
    in_if.first      = (src.size() != 0) ? src[0] : '0;
    in_if.deq__RDY   = deq_rdy;
  endtask

  // One clock: apply inputs, sample handshakes mid-cycle, advance past the edge.
  task automatic tick();
    drive();
    @(negedge CLK);
    if (nRST) begin
      if (in_if.deq__ENA) begin
        check("deq_gate", 64'({in_if.first__RDY, in_if.deq__RDY}), 64'd3);
        deq_cnt++;
        if (first_deq < 0) first_deq = cyc;
        last_deq = cyc;
        if (src.size() != 0) begin
          sb.push_back(ref_sum(src[0]));
          void'(src.pop_front());
        end
      end
      if (out_if.enq__ENA && out_if.enq__RDY) begin
        fire_cnt++;
        exp_count++;
        if (first_fire < 0) first_fire = cyc;
        last_fire = cyc;
        last_val  = out_if.enq_v;
        got.push_back(out_if.enq_v);
        $display("cycle %0d result %h", cyc, out_if.enq_v);
        if (sb.size() == 0) check("sb_empty", 64'(sb.size()), 64'd1);
        else check("result", 64'(out_if.enq_v), 64'(sb.pop_front()));
      end
      if (clear) sb.delete();
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int base_deq, base_fire;
    out_if.enq__RDY = 1'b0;
    drive();

    // Reset state
    tick();
    tick();
    check("rst_ena", 64'(out_if.enq__ENA), 64'd0);
    check("rst_v", 64'(out_if.enq_v), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    nRST = 1'b1;

    // Single entry: result at t+2 only, count 1 at t+3
    src.push_back(mk(48'h5, 48'h7));
    src_en = 1'b1;
    out_if.enq__RDY = 1'b1;
    base_fire = fire_cnt;
    repeat (3) tick();
    check("single_lat", 64'(last_fire - last_deq), 64'd2);
    check("single_val", 64'(last_val), 64'hC);
    check("single_n", 64'(fire_cnt - base_fire), 64'd1);
    check("single_cnt", 64'(count), 64'd1);
    check("single_once", 64'(out_if.enq__ENA), 64'd0);

    // Bring count to 7 then fill A and B under backpressure
    for (int i = 0; i < 6; i++) src.push_back(mk(48'(i + 1), 48'(10 * i)));
    repeat (8) tick();
    out_if.enq__RDY = 1'b0;
    src.push_back(mk(48'h11, 48'h22));
    src.push_back(mk(48'h33, 48'h44));
    repeat (3) tick();
    check("prerst_cnt", 64'(count), 64'd7);
    check("prerst_ena", 64'(out_if.enq__ENA), 64'd1);

    // Mid-operation reset
    nRST = 1'b0;
    src_en = 1'b0;
    tick();
    sb.delete();
    exp_count = '0;
    nRST = 1'b1;
    check("mrst_ena", 64'(out_if.enq__ENA), 64'd0);
    check("mrst_v", 64'(out_if.enq_v), 64'd0);
    check("mrst_cnt", 64'(count), 64'd0);
    src_en = 1'b1;
    out_if.enq__RDY = 1'b1;
    src.push_back(mk(48'h1, 48'h1));
    repeat (3) tick();
    check("post_rst_lat", 64'(last_fire - last_deq), 64'd2);
    check("post_rst_val", 64'(last_val), 64'h2);
    check("post_rst_cnt", 64'(count), 64'd1);

    // deq__RDY low blocks dequeue; then carry cases
    deq_rdy = 1'b0;
    src.push_back(mk(48'hFFFF_FFFF_FFFF, 48'h1));
    src.push_back(mk(48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF));
    base_deq = deq_cnt;
    repeat (3) tick();
    check("deq_rdy_n", 64'(deq_cnt - base_deq), 64'd0);
    check("deq_rdy_ena", 64'(in_if.deq__ENA), 64'd0);
    deq_rdy = 1'b1;
    got.delete();
    repeat (4) tick();
    check("carry_n", 64'(got.size()), 64'd2);
    if (got.size() == 2) begin
      check("carry_one", 64'(got[0]), 64'h1_0000_0000_0000);
      check("carry_max", 64'(got[1]), 64'h1_FFFF_FFFF_FFFE);
    end

    // Stream of 10 at full throughput
    got.delete();
    first_deq = -1;
    first_fire = -1;
    base_deq = deq_cnt;
    base_fire = fire_cnt;
    for (int i = 0; i < 10; i++) src.push_back(mk(48'(i), 48'(2 * i)));
    repeat (13) tick();
    check("stream_deq_n", 64'(deq_cnt - base_deq), 64'd10);
    check("stream_deq_run", 64'(last_deq - first_deq), 64'd9);
    check("stream_fire_n", 64'(fire_cnt - base_fire), 64'd10);
    check("stream_fire_run", 64'(last_fire - first_fire), 64'd9);
    for (int i = 0; i < 10; i++)
      if (i < got.size()) check("stream_val", 64'(got[i]), 64'(3 * i));
    check("stream_cnt", 64'(count), 64'd13);

    // Backpressure: only two entries enter while the sink stalls
    out_if.enq__RDY = 1'b0;
    got.delete();
    base_deq = deq_cnt;
    for (int i = 0; i < 4; i++) src.push_back(mk(48'(32'h1000 * (i + 1)), 48'(i + 1)));
    repeat (5) tick();
    check("bp_deq_n", 64'(deq_cnt - base_deq), 64'd2);
    check("bp_deq_low", 64'(in_if.deq__ENA), 64'd0);
    check("bp_ena", 64'(out_if.enq__ENA), 64'd1);
    check("bp_hold", 64'(out_if.enq_v), 64'h1001);
    check("bp_cnt", 64'(count), 64'd13);
    out_if.enq__RDY = 1'b1;
    first_fire = -1;
    base_fire = fire_cnt;
    repeat (6) tick();
    check("bp_fire_n", 64'(fire_cnt - base_fire), 64'd4);
    check("bp_fire_run", 64'(last_fire - first_fire), 64'd3);
    if (got.size() == 4) check("bp_last", 64'(got[3]), 64'h4004);
    check("bp_cnt2", 64'(count), 64'd17);

    // clear with both stages full and sink stalled
    out_if.enq__RDY = 1'b0;
    base_deq = deq_cnt;
    for (int i = 0; i < 3; i++) src.push_back(mk(48'(50 + i), 48'(i)));
    repeat (3) tick();
    check("clr0_fill", 64'(deq_cnt - base_deq), 64'd2);
    clear = 1'b1;
    base_deq = deq_cnt;
    tick();
    clear = 1'b0;
    check("clr0_nodeq", 64'(deq_cnt - base_deq), 64'd0);
    check("clr0_ena", 64'(out_if.enq__ENA), 64'd0);
    check("clr0_cnt", 64'(count), 64'd17);
    out_if.enq__RDY = 1'b1;
    got.delete();
    repeat (4) tick();
    check("clr0_after_n", 64'(got.size()), 64'd1);
    if (got.size() == 1) check("clr0_after_v", 64'(got[0]), 64'h36);

    // clear with sink ready: B delivers, A dropped
    got.delete();
    for (int i = 0; i < 4; i++) src.push_back(mk(48'(70 + i), 48'(i)));
    repeat (2) tick();
    clear = 1'b1;
    base_deq = deq_cnt;
    tick();
    clear = 1'b0;
    check("clr1_nodeq", 64'(deq_cnt - base_deq), 64'd0);
    check("clr1_ena", 64'(out_if.enq__ENA), 64'd0);
    check("clr1_cnt", 64'(count), 64'd19);
    repeat (4) tick();
    check("clr1_n", 64'(got.size()), 64'd3);
    if (got.size() == 3) begin
      check("clr1_v0", 64'(got[0]), 64'd70);
      check("clr1_v1", 64'(got[1]), 64'd74);
      check("clr1_v2", 64'(got[2]), 64'd76);
    end
    check("final_cnt", 64'(count), 64'd21);
    check("final_model_cnt", 64'(count), 64'(exp_count));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
